cal_mem_port: RTL and testbench
===============================

# cal_mem_port

Shared-memory port multiplexer directly downstream of the CPU/accelerator arbiter in the picture-accelerator datapath. It consumes the arbiter's `arb_res` decision and grants exactly one master (CPU or ACC) access to a single-port synchronous memory. It registers all memory-side outputs and tags every read so that returning data reaches the master that issued it. On each ownership change it drains in-flight reads before the new owner may issue.

## Interface

Parameters:
- `AW`, 10, address width
- `DW`, 16, data width
- `RD_LAT`, 2, memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..4

Ports:
- `clk`  in  1  single clock; all logic samples on posedge
- `rst`  in  1  reset, synchronous, active-high
- `arb_res`  in  1  owner request from the arbiter (`ARB_CPU`=0, `ARB_ACC`=1)
- `cpu_req`, `cpu_we`  in  1 each  CPU access request / write enable
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_gnt`  out  1  CPU access accepted this cycle (combinational)
- `cpu_rvalid`  out  1  CPU read data valid (registered)
- `cpu_rdata`  out  DW  CPU read data
- `acc_req`, `acc_we`, `acc_addr`, `acc_wdata`, `acc_gnt`, `acc_rvalid`, `acc_rdata`  identical set for the accelerator
- `mem_en`, `mem_we`  out  1 each  memory strobe / write enable (registered)
- `mem_addr`  out  AW  memory address (registered)
- `mem_wdata`  out  DW  memory write data (registered)
- `mem_rdata`  in  DW  memory read data
- `busy`  out  1  high while in drain

## Operation

- FSM states are `S_CPU`, `S_ACC` and `S_DRAIN`. Reset state is `S_CPU`, matching the arbiter's reset owner.
- Grant rules:
  - `cpu_gnt = (state==S_CPU) & cpu_req`.
  - `acc_gnt = (state==S_ACC) & acc_req`.
  - Both grants are 0 in `S_DRAIN`.
  - The two grants are never high in the same cycle.
- Issue: on a granted cycle, the next edge loads `mem_en=1` plus the granted master's `we`, `addr` and `wdata`. Otherwise the next edge loads `mem_en=0` and `mem_we=0`, and `mem_addr`/`mem_wdata` hold their values.
- Read tagging:
  - Each issued read (`mem_en & !mem_we`) pushes an owner tag into a valid/tag shift pipe of depth `RD_LAT`.
  - When a tag exits the pipe, `mem_rdata` is registered into that owner's `rdata`, and its `rvalid` pulses for 1 cycle.
  - The other master's `rvalid` stays 0.
  - Writes produce no response.
- Ownership switch:
  - In `S_CPU` with `arb_res==ARB_ACC`, or in `S_ACC` with `arb_res==ARB_CPU`:
    - go to `S_DRAIN`;
    - latch the target owner;
    - load the drain counter with `RD_LAT+1`.
  - In `S_DRAIN` the counter decrements each cycle. When it reaches 1, the next state is the latched target.
  - `arb_res` is ignored during drain. A reversal is handled only after arrival, by a fresh drain.
- `busy = (state==S_DRAIN)`.
- Write data and addresses pass through unmodified. No arithmetic beyond the drain counter, which is 3 bits wide.

## Timing

- Reset values:
  - all `mem_*` outputs are 0;
  - `cpu_rvalid`, `acc_rvalid`, `cpu_rdata` and `acc_rdata` are 0;
  - `busy` is 0;
  - the tag pipe is cleared.
- Reset mid-operation discards all pending reads, and no `rvalid` follows the reset.
- Write latency: grant at cycle t gives `mem_en`/`mem_we` at t+1.
- Read latency: grant at t gives `mem_en` at t+1, `mem_rdata` sampled at t+1+`RD_LAT`, and `rvalid` at t+2+`RD_LAT`.
- Throughput is 1 access per cycle for the owner with `req` held. Back-to-back reads return in issue order, 1 per cycle.
- Switch timing:
  - `arb_res` change sampled at cycle s.
  - `S_DRAIN` covers s+1 .. s+1+`RD_LAT`.
  - New owner state starts at s+2+`RD_LAT`.
  - A grant at s, the last old-owner grant, still completes with correct routing.
- `cpu_req`/`acc_req` may be held without a grant. Masters keep `addr`, `we` and `wdata` stable until granted.

## Structure

- The shared header `cal_head.v` holds `ARB_CPU`, `ARB_ACC`, the state encodings `S_CPU`/`S_ACC`/`S_DRAIN`, and the `RD_LAT` limit.
- One sub-module, `cal_rd_tag_pipe`, implements the `RD_LAT`-deep valid/owner shift pipe. Its output is a response-valid and owner tag.
- The FSM, issue registers and response demux live in `cal_mem_port`.

## Test plan

Bench uses a behavioural SRAM model with `RD_LAT`=2.

- Reset: hold `rst` for 3 cycles with `cpu_req`=1 → all outputs 0 during reset. After release, `cpu_gnt`=1 and `acc_gnt`=0.
- CPU write `addr`=0x005, `wdata`=0xBEEF granted at t → at t+1, `mem_en`=1, `mem_we`=1, `mem_addr`=0x005, `mem_wdata`=0xBEEF. `cpu_rvalid` never pulses.
- CPU back-to-back reads of addresses 1, 2, 3 granted at t..t+2 → `cpu_rvalid` at t+4, t+5, t+6 with model data in order; `acc_rvalid` stays 0.
- Switch with a read in flight: CPU read at t, `arb_res`→ACC at t+1, `acc_req` held → `busy`=1 over t+2..t+4. `cpu_rvalid` appears at t+4 (t+5 if the CPU was also granted at t+1). `acc_gnt` is first high at t+5.
- Reversal during drain: `arb_res` toggles ACC at s, then back to CPU at s+2 → `S_ACC` reached at s+4. Immediate second drain follows, and the state is back in `S_CPU` at s+8.
- Reset mid-read: CPU read granted at t, `rst` at t+2 → no `cpu_rvalid` at t+4, and state is `S_CPU`.

Source files
------------

// File: rtl/cal_mem_port_pkg.sv
// Shared definitions for the CPU/accelerator memory port multiplexer:
// owner codes, FSM encodings and read-latency limits.
package cal_mem_port_pkg;

   // Owner codes as produced by the upstream arbiter.
   localparam logic ARB_CPU = 1'b0;
   localparam logic ARB_ACC = 1'b1;

   // Legal read latency range and the width of the drain counter.
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;
   localparam int DRAIN_W    = 3;

   typedef enum logic [1:0] {
      S_CPU   = 2'd0,
      S_ACC   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   // Steady state that corresponds to an owner code.
   function automatic state_t owner_state(input logic owner);
      return (owner == ARB_ACC) ? S_ACC : S_CPU;
   endfunction

endpackage

// File: rtl/cal_mem_port_rd_tag_pipe.sv
// Valid/owner shift pipe, RD_LAT stages deep. Its output lines up with the
// cycle in which the memory presents the data for the read that was pushed.
module cal_rd_tag_pipe
   import cal_mem_port_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push_valid,
   input  logic push_owner,
   output logic pop_valid,
   output logic pop_owner
);

   genvar gi;
   generate
      for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
         logic valid_reg;
         logic owner_reg;
         logic valid_in;
         logic owner_in;

         if (gi == 0) begin : g_head
            assign valid_in = push_valid;
            assign owner_in = push_owner;
         end else begin : g_link
            assign valid_in = g_stage[gi-1].valid_reg;
            assign owner_in = g_stage[gi-1].owner_reg;
         end

         // Clearing every stage on reset drops all reads still in flight.
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg <= 1'b0;
               owner_reg <= ARB_CPU;
            end else begin
               valid_reg <= valid_in;
               owner_reg <= owner_in;
            end
         end
      end
   endgenerate

   assign pop_valid = g_stage[RD_LAT-1].valid_reg;
   assign pop_owner = g_stage[RD_LAT-1].owner_reg;

endmodule

// File: rtl/cal_mem_port.sv
// Single-port memory multiplexer between CPU and accelerator: owner FSM with
// read drain on hand-over, registered memory strobes and tagged read return.
module cal_mem_port
   import cal_mem_port_pkg::*;
#(
   parameter int AW     = 10,
   parameter int DW     = 16,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arb_res,

   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,

   input  logic          acc_req,
   input  logic          acc_we,
   input  logic [AW-1:0] acc_addr,
   input  logic [DW-1:0] acc_wdata,
   output logic          acc_gnt,
   output logic          acc_rvalid,
   output logic [DW-1:0] acc_rdata,

   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,

   output logic          busy
);

   // One cycle for the memory strobe register plus RD_LAT for the read.
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(RD_LAT + 1);

   state_t               state_reg, state_next;
   logic                 target_reg, target_next;
   logic [DRAIN_W-1:0]   drain_cnt_reg, drain_cnt_next;
   logic                 mem_owner_reg;
   logic                 pop_valid;
   logic                 pop_owner;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_CPU;
         target_reg    <= ARB_CPU;
         drain_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         target_reg    <= target_next;
         drain_cnt_reg <= drain_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      target_next    = target_reg;
      drain_cnt_next = drain_cnt_reg;
      case (state_reg)
         S_CPU: begin
            if (arb_res == ARB_ACC) begin
               state_next     = S_DRAIN;
               target_next    = ARB_ACC;
               drain_cnt_next = DRAIN_LOAD;
            end
         end
         S_ACC: begin
            if (arb_res == ARB_CPU) begin
               state_next     = S_DRAIN;
               target_next    = ARB_CPU;
               drain_cnt_next = DRAIN_LOAD;
            end
         end
         S_DRAIN: begin
            // arb_res is deliberately not looked at until the target is reached.
            drain_cnt_next = drain_cnt_reg - 1'b1;
            if (drain_cnt_reg == DRAIN_W'(1)) begin
               state_next = owner_state(target_reg);
            end
         end
         default: begin
            state_next = S_CPU;
         end
      endcase
   end

   // Grants are also held off while rst is high so no access is accepted
   // on a cycle whose issue registers are being cleared.
   always_comb begin
      cpu_gnt = (state_reg == S_CPU) && cpu_req && !rst;
      acc_gnt = (state_reg == S_ACC) && acc_req && !rst;
      busy    = (state_reg == S_DRAIN);
   end

   // ------------------------------------------------------ issue registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_owner_reg <= ARB_CPU;
      end else if (cpu_gnt) begin
         mem_en        <= 1'b1;
         mem_we        <= cpu_we;
         mem_addr      <= cpu_addr;
         mem_wdata     <= cpu_wdata;
         mem_owner_reg <= ARB_CPU;
      end else if (acc_gnt) begin
         mem_en        <= 1'b1;
         mem_we        <= acc_we;
         mem_addr      <= acc_addr;
         mem_wdata     <= acc_wdata;
         mem_owner_reg <= ARB_ACC;
      end else begin
         mem_en <= 1'b0;
         mem_we <= 1'b0;
      end
   end

   // ------------------------------------------------------ read tag pipe
   cal_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk        (clk),
      .rst        (rst),
      .push_valid (mem_en && !mem_we),
      .push_owner (mem_owner_reg),
      .pop_valid  (pop_valid),
      .pop_owner  (pop_owner)
   );

   // ---------------------------------------------------- response demux
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rvalid <= 1'b0;
         acc_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         acc_rdata  <= '0;
      end else begin
         cpu_rvalid <= pop_valid && (pop_owner == ARB_CPU);
         acc_rvalid <= pop_valid && (pop_owner == ARB_ACC);
         if (pop_valid && (pop_owner == ARB_CPU)) begin
            cpu_rdata <= mem_rdata;
         end
         if (pop_valid && (pop_owner == ARB_ACC)) begin
            acc_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_cal_mem_port.sv
// Directed bench for cal_mem_port: vector table for issue/grant behaviour plus
// hand-written sequences for read latency, hand-over drain and reset.
module tb_cal_mem_port;

   logic        clk;
   logic        rst;
   logic        arb_res;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [9:0]  cpu_addr;
   logic [15:0] cpu_wdata, cpu_rdata;
   logic        acc_req, acc_we, acc_gnt, acc_rvalid;
   logic [9:0]  acc_addr;
   logic [15:0] acc_wdata, acc_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        busy;

   int total = 0;
   int bad   = 0;

   cal_mem_port #(.AW(10), .DW(16), .RD_LAT(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .arb_res    (arb_res),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .acc_req    (acc_req),
      .acc_we     (acc_we),
      .acc_addr   (acc_addr),
      .acc_wdata  (acc_wdata),
      .acc_gnt    (acc_gnt),
      .acc_rvalid (acc_rvalid),
      .acc_rdata  (acc_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM with 2-cycle read latency; unwritten words read as 0xC000|addr.
   logic [15:0]   sram [0:1023];
   logic [1023:0] written;
   logic [15:0]   rd_p0, rd_p1;
   always @(posedge clk) begin
      if (rst) begin
         written <= '0;
      end else if (mem_en && mem_we) begin
         sram[mem_addr]    <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
      if (mem_en && !mem_we) begin
         rd_p0 <= written[mem_addr] ? sram[mem_addr] : (16'hC000 | 16'(mem_addr));
      end
      rd_p1 <= rd_p0;
   end
   assign mem_rdata = rd_p1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   typedef struct {
      logic        cpu_req;
      logic        cpu_we;
      logic [9:0]  cpu_addr;
      logic [15:0] cpu_wdata;
      logic        acc_req;
      logic        e_cpu_gnt;
      logic        e_acc_gnt;
      logic        e_en;
      logic        e_we;
      logic [9:0]  e_addr;
      logic [15:0] e_wdata;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // cpu_req, we, addr, wdata, acc_req | gnt cpu/acc, en, we, addr, wdata
      vecs[0] = '{1'b1, 1'b1, 10'h005, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'h005, 16'hBEEF};
      vecs[1] = '{1'b0, 1'b1, 10'h111, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h005, 16'hBEEF};
      vecs[2] = '{1'b1, 1'b1, 10'h010, 16'h00AA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h010, 16'h00AA};
      vecs[3] = '{1'b1, 1'b1, 10'h3FF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'h3FF, 16'hFFFF};
      vecs[4] = '{1'b0, 1'b0, 10'h001, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF, 16'hFFFF};
      vecs[5] = '{1'b1, 1'b1, 10'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'h000, 16'h0000};

      // Reset held 3 cycles with cpu_req asserted: everything stays 0.
      rst = 1'b1; arb_res = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h000; cpu_wdata = 16'h0000;
      acc_req = 1'b0; acc_we = 1'b1; acc_addr = 10'h3FF; acc_wdata = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rst%0d cpu_gnt", i),    32'(cpu_gnt),    32'd0);
         check($sformatf("rst%0d acc_gnt", i),    32'(acc_gnt),    32'd0);
         check($sformatf("rst%0d mem_en", i),     32'(mem_en),     32'd0);
         check($sformatf("rst%0d mem_we", i),     32'(mem_we),     32'd0);
         check($sformatf("rst%0d mem_addr", i),   32'(mem_addr),   32'd0);
         check($sformatf("rst%0d mem_wdata", i),  32'(mem_wdata),  32'd0);
         check($sformatf("rst%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'd0);
         check($sformatf("rst%0d acc_rvalid", i), 32'(acc_rvalid), 32'd0);
         check($sformatf("rst%0d cpu_rdata", i),  32'(cpu_rdata),  32'd0);
         check($sformatf("rst%0d acc_rdata", i),  32'(acc_rdata),  32'd0);
         check($sformatf("rst%0d busy", i),       32'(busy),       32'd0);
      end
      rst = 1'b0;
      #1;
      check("post-rst cpu_gnt", 32'(cpu_gnt), 32'd1);
      check("post-rst acc_gnt", 32'(acc_gnt), 32'd0);

      // Vector table: writes and idle cycles in S_CPU.
      for (int i = 0; i < 6; i++) begin
         cpu_req   = vecs[i].cpu_req;
         cpu_we    = vecs[i].cpu_we;
         cpu_addr  = vecs[i].cpu_addr;
         cpu_wdata = vecs[i].cpu_wdata;
         acc_req   = vecs[i].acc_req;
         #1;
         check($sformatf("vec%0d cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].e_cpu_gnt));
         check($sformatf("vec%0d acc_gnt", i), 32'(acc_gnt), 32'(vecs[i].e_acc_gnt));
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d mem_en", i),     32'(mem_en),     32'(vecs[i].e_en));
         check($sformatf("vec%0d mem_we", i),     32'(mem_we),     32'(vecs[i].e_we));
         check($sformatf("vec%0d mem_addr", i),   32'(mem_addr),   32'(vecs[i].e_addr));
         check($sformatf("vec%0d mem_wdata", i),  32'(mem_wdata),  32'(vecs[i].e_wdata));
         check($sformatf("vec%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'd0);
         check($sformatf("vec%0d acc_rvalid", i), 32'(acc_rvalid), 32'd0);
      end
      cpu_req = 1'b0; acc_req = 1'b0;

      // Back-to-back CPU reads of 1,2,3 granted at k=0..2, data at k=4..6.
      for (int k = 0; k < 9; k++) begin
         check($sformatf("b2b k%0d cpu_rvalid", k), 32'(cpu_rvalid), 32'(k >= 4 && k <= 6));
         check($sformatf("b2b k%0d acc_rvalid", k), 32'(acc_rvalid), 32'd0);
         if (k >= 4 && k <= 6)
            check($sformatf("b2b k%0d cpu_rdata", k), 32'(cpu_rdata), 32'(16'hC000 + 16'(k - 3)));
         cpu_req  = (k < 3);
         cpu_we   = 1'b0;
         cpu_addr = 10'(k + 1);
         @(posedge clk);
         @(negedge clk);
      end
      cpu_req = 1'b0;

      // Hand-over with a CPU read in flight; arb_res goes to ACC at k=1.
      acc_we = 1'b0; acc_addr = 10'h005;
      for (int k = 0; k < 11; k++) begin
         check($sformatf("sw k%0d busy", k),       32'(busy),       32'(k >= 2 && k <= 4));
         check($sformatf("sw k%0d cpu_rvalid", k), 32'(cpu_rvalid), 32'(k == 4));
         check($sformatf("sw k%0d acc_rvalid", k), 32'(acc_rvalid), 32'(k == 9));
         if (k == 4) check("sw cpu_rdata", 32'(cpu_rdata), 32'h0000C002);
         if (k == 9) check("sw acc_rdata", 32'(acc_rdata), 32'h0000BEEF);
         cpu_req  = (k == 0);
         cpu_we   = 1'b0;
         cpu_addr = 10'h002;
         arb_res  = (k >= 1);
         acc_req  = (k <= 5);
         #1;
         check($sformatf("sw k%0d acc_gnt", k), 32'(acc_gnt), 32'(k == 5));
         check($sformatf("sw k%0d cpu_gnt", k), 32'(cpu_gnt), 32'(k == 0));
         @(posedge clk);
         @(negedge clk);
      end
      acc_req = 1'b0;

      // Reset from S_ACC returns to S_CPU.
      rst = 1'b1; arb_res = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst2 busy", 32'(busy), 32'd0);

      // Reversal during drain: ACC at k=0..1, CPU again from k=2.
      cpu_we = 1'b1; cpu_addr = 10'h200; cpu_wdata = 16'h0200;
      acc_we = 1'b1; acc_addr = 10'h201; acc_wdata = 16'h0201;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("rev k%0d busy", k), 32'(busy),
               32'((k >= 1 && k <= 3) || (k >= 5 && k <= 7)));
         check($sformatf("rev k%0d mem_en", k), 32'(mem_en), 32'(k == 1 || k == 5 || k == 9));
         cpu_req = 1'b1;
         acc_req = 1'b1;
         arb_res = (k <= 1);
         #1;
         check($sformatf("rev k%0d cpu_gnt", k), 32'(cpu_gnt), 32'(k == 0 || k >= 8));
         check($sformatf("rev k%0d acc_gnt", k), 32'(acc_gnt), 32'(k == 4));
         @(posedge clk);
         @(negedge clk);
      end
      cpu_req = 1'b0; acc_req = 1'b0;

      // CPU read at k=0, reset during k=2: its response must never appear.
      for (int k = 0; k < 7; k++) begin
         check($sformatf("rstrd k%0d cpu_rvalid", k), 32'(cpu_rvalid), 32'd0);
         check($sformatf("rstrd k%0d acc_rvalid", k), 32'(acc_rvalid), 32'd0);
         if (k == 3) check("rstrd mem_en", 32'(mem_en), 32'd0);
         cpu_req  = (k == 0 || k == 4);
         cpu_we   = (k == 4);
         cpu_addr = 10'h003;
         rst      = (k == 2);
         #1;
         if (k == 4) begin
            check("rstrd cpu_gnt", 32'(cpu_gnt), 32'd1);
            check("rstrd busy",    32'(busy),    32'd0);
         end
         @(posedge clk);
         @(negedge clk);
      end
      cpu_req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
